// File: rtl/pakin_reassembler_pkg.sv
// Shared types and sizing for the packet-in reassembler.
// Default sizes match the small link configuration (PSZ=4, ASZ=6, DSZ=4, RSZ=4, FSZ=2).
package pakin_reassembler_pkg;

   localparam int NS_PACKET_SIZE  = 4;
   localparam int NS_PACKIN_FSZ   = 2;
   localparam int NS_ADDRESS_SIZE = 6;
   localparam int NS_DATA_SIZE    = 4;
   localparam int NS_REDUN_SIZE   = 4;

   typedef enum logic [1:0] {
      RX_SYNC = 2'd0,
      RX_IDLE = 2'd1,
      RX_CHK  = 2'd2,
      RX_ACK  = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_REQ  = 2'd1,
      TX_WAIT = 2'd2
   } tx_state_t;

   // Number of packets needed to carry a full message word.
   function automatic int tot_pks(input int full_msg_sz, input int pk_sz);
      return (full_msg_sz + pk_sz - 1) / pk_sz;
   endfunction

endpackage

// File: rtl/pakin_msg_fifo.sv
// Message FIFO, DEPTH x W, power-of-two depth so pointers wrap naturally.
// Push and pop may coincide; the occupancy count is then unchanged.
module pakin_msg_fifo #(
   parameter int W     = 20,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pakin_reassembler.sv
// Packet-in reassembler: collects TOT_PKS packets from a 4-phase packet channel into one
// message word {src, dst, dat, red}, buffers it and re-emits it on a 4-phase message channel.
// Optional feature macro NS_PAKIN_RED_CHECK_EN: when defined, messages whose redundancy does
// not match calc_redun(src, dst, dat) are acked but dropped and counted as errors.
//
// RX state | meaning
// RX_SYNC  | after reset, wait for a clean low on req so a stale request is not taken
// RX_IDLE  | wait for req, capture packet into slot pk_idx
// RX_CHK   | full message assembled; push (or drop), stall while FIFO full
// RX_ACK   | ack held high until req falls
//
// TX state | meaning
// TX_IDLE  | wait for a buffered message, load it and raise req
// TX_REQ   | req high, wait for ack, then pop
// TX_WAIT  | wait for ack to fall
module pakin_reassembler
   import pakin_reassembler_pkg::*;
#(
   parameter int PSZ = NS_PACKET_SIZE,
   parameter int FSZ = NS_PACKIN_FSZ,
   parameter int ASZ = NS_ADDRESS_SIZE,
   parameter int DSZ = NS_DATA_SIZE,
   parameter int RSZ = NS_REDUN_SIZE
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [PSZ-1:0] i0_pakio,
   input  logic           i0_req,
   output logic           i0_ack,
   output logic [ASZ-1:0] o0_src,
   output logic [ASZ-1:0] o0_dst,
   output logic [DSZ-1:0] o0_dat,
   output logic [RSZ-1:0] o0_red,
   output logic           o0_req,
   input  logic           o0_ack,
   output logic [3:0]     dbg_leds,
   output logic [3:0]     dbg_disp0,
   output logic [3:0]     dbg_disp1
);

   localparam int MSZ     = 2*ASZ + DSZ + RSZ;
   localparam int TOT_PKS = tot_pks(MSZ, PSZ);
   localparam int BUFW    = TOT_PKS * PSZ;
   localparam int PKW     = (TOT_PKS > 1) ? $clog2(TOT_PKS) : 1;
   localparam logic [PKW-1:0] LAST_PK = PKW'(TOT_PKS - 1);

   localparam int RED_LO = 0;
   localparam int DAT_LO = RSZ;
   localparam int DST_LO = RSZ + DSZ;
   localparam int SRC_LO = RSZ + DSZ + ASZ;

   rx_state_t      rx_state;
   tx_state_t      tx_state;
   logic [PKW-1:0] pk_idx;
   logic [BUFW-1:0] msg_buf;
   logic [MSZ-1:0] msg_word;
   logic [MSZ-1:0] fifo_head;
   logic           fifo_full;
   logic           fifo_empty;
   logic           push;
   logic           pop;
   logic           drop;
   logic           red_bad;
   logic           rx_stall;
   logic           prot_lvl;
   logic           prot_ev;

   logic           req_meta;
   logic           ckd_req;
   logic           ack_meta;
   logic           ckd_ack;
   logic           ack_d;

   logic           led_red;
   logic           led_full;
   logic           led_prot;
   logic [3:0]     err_cnt;
   logic [4:0]     err_sum;

   // Redundancy: XOR-fold of {src, dst, dat} onto RSZ bits.
   function automatic logic [RSZ-1:0] calc_redun(input logic [ASZ-1:0] src,
                                                 input logic [ASZ-1:0] dst,
                                                 input logic [DSZ-1:0] dat);
      logic [2*ASZ+DSZ-1:0] body;
      logic [RSZ-1:0]       r;
      body = {src, dst, dat};
      r    = '0;
      for (int i = 0; i < 2*ASZ+DSZ; i++) r[i % RSZ] = r[i % RSZ] ^ body[i];
      return r;
   endfunction

   assign msg_word = msg_buf[MSZ-1:0];

`ifdef NS_PAKIN_RED_CHECK_EN
   assign red_bad = (msg_word[RED_LO +: RSZ] !=
                     calc_redun(msg_word[SRC_LO +: ASZ], msg_word[DST_LO +: ASZ],
                                msg_word[DAT_LO +: DSZ]));
`else
   assign red_bad = 1'b0;
`endif

   assign rx_stall = (rx_state == RX_CHK) && fifo_full;
   assign push     = (rx_state == RX_CHK) && !fifo_full && !red_bad;
   assign drop     = (rx_state == RX_CHK) && !fifo_full && red_bad;
   assign pop      = (tx_state == TX_REQ) && ckd_ack;
   assign prot_lvl = (tx_state == TX_IDLE) && ckd_ack;
   assign prot_ev  = prot_lvl && !ack_d;

   // Req sync resets to 1 so RX_SYNC always waits for a genuine low after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_meta <= 1'b1;
         ckd_req  <= 1'b1;
         ack_meta <= 1'b0;
         ckd_ack  <= 1'b0;
         ack_d    <= 1'b0;
      end else begin
         req_meta <= i0_req;
         ckd_req  <= req_meta;
         ack_meta <= o0_ack;
         ckd_ack  <= ack_meta;
         ack_d    <= ckd_ack;
      end
   end

   // Receive FSM: packet capture, message check/push and input handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= RX_SYNC;
         pk_idx   <= '0;
         msg_buf  <= '0;
         i0_ack   <= 1'b0;
      end else begin
         case (rx_state)
            RX_SYNC: if (!ckd_req) rx_state <= RX_IDLE;
            RX_IDLE: begin
               if (ckd_req) begin
                  msg_buf[int'(pk_idx)*PSZ +: PSZ] <= i0_pakio;
                  if (pk_idx == LAST_PK) begin
                     pk_idx   <= '0;
                     rx_state <= RX_CHK;
                  end else begin
                     pk_idx   <= pk_idx + 1'b1;
                     i0_ack   <= 1'b1;
                     rx_state <= RX_ACK;
                  end
               end
            end
            RX_CHK: begin
               if (!fifo_full) begin
                  i0_ack   <= 1'b1;
                  rx_state <= RX_ACK;
               end
            end
            RX_ACK: begin
               if (!ckd_req) begin
                  i0_ack   <= 1'b0;
                  rx_state <= RX_IDLE;
               end
            end
            default: rx_state <= RX_SYNC;
         endcase
      end
   end

   // Transmit FSM: present head message and run the output handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state  <= TX_IDLE;
         o0_src    <= '0;
         o0_dst    <= '0;
         o0_dat    <= '0;
         o0_red    <= '0;
         o0_req    <= 1'b0;
         dbg_disp0 <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (!fifo_empty) begin
                  o0_src   <= fifo_head[SRC_LO +: ASZ];
                  o0_dst   <= fifo_head[DST_LO +: ASZ];
                  o0_dat   <= fifo_head[DAT_LO +: DSZ];
                  o0_red   <= fifo_head[RED_LO +: RSZ];
                  o0_req   <= 1'b1;
                  tx_state <= TX_REQ;
               end
            end
            TX_REQ: begin
               if (ckd_ack) begin
                  o0_req    <= 1'b0;
                  dbg_disp0 <= o0_dat[3:0];
                  tx_state  <= TX_WAIT;
               end
            end
            TX_WAIT: if (!ckd_ack) tx_state <= TX_IDLE;
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   always_comb begin
      err_sum = {1'b0, err_cnt} + {4'b0, drop} + {4'b0, prot_ev};
   end

   // Sticky debug flags and saturating error counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_red  <= 1'b0;
         led_full <= 1'b0;
         led_prot <= 1'b0;
         err_cnt  <= '0;
      end else begin
         if (drop)     led_red  <= 1'b1;
         if (rx_stall) led_full <= 1'b1;
         if (prot_lvl) led_prot <= 1'b1;
         err_cnt <= (err_sum > 5'd15) ? 4'd15 : err_sum[3:0];
      end
   end

   assign dbg_leds  = {led_red | led_full | led_prot, led_prot, led_full, led_red};
   assign dbg_disp1 = err_cnt;

   pakin_msg_fifo #(
      .W     (MSZ),
      .DEPTH (FSZ)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (msg_word),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_pakin_reassembler.sv
// Bench for pakin_reassembler with PSZ=4, ASZ=6, DSZ=4, RSZ=4 (MSZ=20, 5 packets), FSZ=2.
module tb_pakin_reassembler;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] i0_pakio;
   logic       i0_req;
   logic       i0_ack;
   logic [5:0] o0_src;
   logic [5:0] o0_dst;
   logic [3:0] o0_dat;
   logic [3:0] o0_red;
   logic       o0_req;
   logic       o0_ack;
   logic [3:0] dbg_leds;
   logic [3:0] dbg_disp0;
   logic [3:0] dbg_disp1;

   int total = 0;
   int bad   = 0;
   logic [19:0] exp_q[$];

   typedef struct {
      logic [5:0] src;
      logic [5:0] dst;
      logic [3:0] dat;
      logic [3:0] exp_disp0;
   } vec_t;
   vec_t vecs[4];

   always #5 clk = ~clk;

   pakin_reassembler #(
      .PSZ(4), .FSZ(2), .ASZ(6), .DSZ(4), .RSZ(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i0_pakio  (i0_pakio),
      .i0_req    (i0_req),
      .i0_ack    (i0_ack),
      .o0_src    (o0_src),
      .o0_dst    (o0_dst),
      .o0_dat    (o0_dat),
      .o0_red    (o0_red),
      .o0_req    (o0_req),
      .o0_ack    (o0_ack),
      .dbg_leds  (dbg_leds),
      .dbg_disp0 (dbg_disp0),
      .dbg_disp1 (dbg_disp1)
   );

   // Reference redundancy: XOR of the four nibbles of {src,dst,dat}.
   function automatic logic [3:0] model_red(input logic [5:0] s, input logic [5:0] d,
                                            input logic [3:0] t);
      logic [15:0] b;
      b = {s, d, t};
      return b[3:0] ^ b[7:4] ^ b[11:8] ^ b[15:12];
   endfunction

   function automatic logic [19:0] mk_msg(input logic [5:0] s, input logic [5:0] d,
                                          input logic [3:0] t, input logic [3:0] r);
      return {s, d, t, r};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      i0_req = 1'b0;
      o0_ack = 1'b0;
      i0_pakio = '0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      repeat (4) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [3:0] d, input int budget, output bit ok);
      @(negedge clk);
      i0_pakio = d;
      i0_req   = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (i0_ack) begin ok = 1'b1; break; end
      end
      if (!ok) return;
      i0_req = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!i0_ack) begin ok = 1'b1; break; end
      end
   endtask

   task automatic send_msg(input logic [19:0] w, input bit expect_out, input int budget);
      bit ok;
      if (expect_out) exp_q.push_back(w);
      for (int k = 0; k < 5; k++) begin
         send_pkt(w[k*4 +: 4], budget, ok);
         check("pkt_handshake", ok, 1);
         if (!ok) begin i0_req = 1'b0; return; end
      end
   endtask

   task automatic recv_msg(input string name);
      bit got;
      logic [19:0] e;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (o0_req) begin got = 1'b1; break; end
      end
      check({name, "_req_rise"}, got, 1);
      if (!got) return;
      check({name, "_sb_nonempty"}, exp_q.size() != 0, 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check({name, "_src"}, o0_src, e[19:14]);
      check({name, "_dst"}, o0_dst, e[13:8]);
      check({name, "_dat"}, o0_dat, e[7:4]);
      check({name, "_red"}, o0_red, e[3:0]);
      o0_ack = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!o0_req) begin got = 1'b1; break; end
      end
      check({name, "_req_fall"}, got, 1);
      check({name, "_dat_stable"}, o0_dat, e[7:4]);
      o0_ack = 1'b0;
      repeat (4) @(negedge clk);
      check({name, "_disp0"}, dbg_disp0, e[7:4]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] w;
      bit ok;
      vecs[0] = '{src: 6'd63, dst: 6'd0,  dat: 4'd15, exp_disp0: 4'd15};
      vecs[1] = '{src: 6'd0,  dst: 6'd63, dat: 4'd0,  exp_disp0: 4'd0};
      vecs[2] = '{src: 6'd21, dst: 6'd42, dat: 4'd10, exp_disp0: 4'd10};
      vecs[3] = '{src: 6'd1,  dst: 6'd1,  dat: 4'd1,  exp_disp0: 4'd1};

      // Reset state
      do_reset();
      check("rst_i0_ack", i0_ack, 0);
      check("rst_o0_req", o0_req, 0);
      check("rst_o0_src", o0_src, 0);
      check("rst_o0_dst", o0_dst, 0);
      check("rst_o0_dat", o0_dat, 0);
      check("rst_o0_red", o0_red, 0);
      check("rst_leds",   dbg_leds, 0);
      check("rst_disp0",  dbg_disp0, 0);
      check("rst_disp1",  dbg_disp1, 0);

      // Single message 3/2/5
      send_msg(mk_msg(6'd3, 6'd2, 4'd5, model_red(6'd3, 6'd2, 4'd5)), 1'b1, 100);
      recv_msg("single");
      check("single_leds", dbg_leds, 0);
      check("single_disp0", dbg_disp0, 5);

      // Table-driven messages
      for (int v = 0; v < 4; v++) begin
         send_msg(mk_msg(vecs[v].src, vecs[v].dst, vecs[v].dat,
                         model_red(vecs[v].src, vecs[v].dst, vecs[v].dat)), 1'b1, 100);
         recv_msg("table");
         check("table_disp0", dbg_disp0, vecs[v].exp_disp0);
      end

      // Three messages with o0_ack held low: FIFO fills, third final packet stalls
      do_reset();
      fork
         begin
            for (int m = 5; m <= 7; m++)
               send_msg(mk_msg(6'(m), 6'(m + 8), 4'(m), model_red(6'(m), 6'(m + 8), 4'(m))),
                        1'b1, 600);
         end
         begin
            repeat (250) @(negedge clk);
            check("stall_no_ack", i0_ack, 0);
            check("stall_led1", dbg_leds[1], 1);
            check("stall_o0_req", o0_req, 1);
            check("stall_o0_dat", o0_dat, 5);
            recv_msg("order1");
            recv_msg("order2");
            recv_msg("order3");
         end
      join
      check("stall_led1_sticky", dbg_leds[1], 1);
      check("stall_led3", dbg_leds[3], 1);

      // Corrupted redundancy
      do_reset();
      w = mk_msg(6'd9, 6'd4, 4'd3, model_red(6'd9, 6'd4, 4'd3) ^ 4'd1);
`ifdef NS_PAKIN_RED_CHECK_EN
      send_msg(w, 1'b0, 100);
      repeat (30) @(negedge clk);
      check("redbad_o0_req", o0_req, 0);
      check("redbad_led0", dbg_leds[0], 1);
      check("redbad_led3", dbg_leds[3], 1);
      check("redbad_disp1", dbg_disp1, 1);
`else
      send_msg(w, 1'b1, 100);
      recv_msg("redpass");
      check("redpass_leds", dbg_leds, 0);
      check("redpass_disp1", dbg_disp1, 0);
`endif

      // Reset after packet 2 with i0_req still high
      do_reset();
      w = mk_msg(6'd40, 6'd17, 4'd12, model_red(6'd40, 6'd17, 4'd12));
      send_pkt(w[3:0], 100, ok);
      check("midrst_pkt0", ok, 1);
      send_pkt(w[7:4], 100, ok);
      check("midrst_pkt1", ok, 1);
      @(negedge clk);
      i0_pakio = w[11:8];
      i0_req   = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      check("midrst_ack_low", i0_ack, 0);
      repeat (20) @(negedge clk);
      check("midrst_no_ack", i0_ack, 0);
      check("midrst_no_req", o0_req, 0);
      i0_req = 1'b0;
      repeat (6) @(negedge clk);
      w = mk_msg(6'd33, 6'd6, 4'd9, model_red(6'd33, 6'd6, 4'd9));
      send_msg(w, 1'b1, 100);
      recv_msg("midrst");

      // Spurious o0_ack while idle
      do_reset();
      o0_ack = 1'b1;
      repeat (4) @(negedge clk);
      o0_ack = 1'b0;
      repeat (6) @(negedge clk);
      check("spur_led2", dbg_leds[2], 1);
      check("spur_led3", dbg_leds[3], 1);
      check("spur_disp1", dbg_disp1, 1);
      check("spur_o0_req", o0_req, 0);
      send_msg(mk_msg(6'd2, 6'd3, 4'd11, model_red(6'd2, 6'd3, 4'd11)), 1'b1, 100);
      recv_msg("after_spur");

      // Error counter saturates at 15
      for (int p = 0; p < 17; p++) begin
         o0_ack = 1'b1;
         repeat (3) @(negedge clk);
         o0_ack = 1'b0;
         repeat (6) @(negedge clk);
      end
      check("err_saturate", dbg_disp1, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
